// File: rtl/wash_panel_ctrl.sv
// Front-panel controller for the washer: debounces the two panel buttons,
// runs the IDLE/START/RUN/DONE sequencing towards the washer FSM and drives
// the BCD time display, door/soap/running LEDs and the completion buzzer.
// Every output comes straight from a flop.
module wash_panel_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BUZZ_CYCLES     = 20,
  parameter int unsigned BLINK_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power,
  input  logic       btn_next,
  input  logic       btn_start,
  input  logic       doorclosed,
  input  logic [7:0] timer_display,
  input  logic       program_done,
  input  logic       soap_warning,
  output logic [2:0] program_selection,
  output logic       start,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic       led_running,
  output logic       led_door,
  output logic       led_soap,
  output logic       buzzer
);

  localparam int unsigned NBTN = 2;
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BZ_W = $clog2(BUZZ_CYCLES + 1);
  localparam int unsigned BL_W = $clog2(BLINK_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } state_t;

  // Index 0 = program-select button, index 1 = start button.
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] press;

  assign btn_raw = {btn_start, btn_next};

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    logic            sync_a;
    logic            sync_b;
    logic            db_lvl;
    logic            db_lvl_q;
    logic [DB_W-1:0] db_cnt;

    // Two-flop synchroniser for the asynchronous raw button.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_a <= 1'b0;
        sync_b <= 1'b0;
      end else begin
        sync_a <= btn_raw[g];
        sync_b <= sync_a;
      end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        db_lvl <= 1'b0;
        db_cnt <= '0;
      end else if (sync_b == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_lvl <= sync_b;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end

    // Previous debounced level, used to form the one-cycle press event.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        db_lvl_q <= 1'b0;
      end else begin
        db_lvl_q <= db_lvl;
      end
    end

    assign press[g] = db_lvl & ~db_lvl_q;
  end

  logic pd_q;
  logic done_rise;

  // Registered copy of program_done for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pd_q <= 1'b0;
    end else begin
      pd_q <= program_done;
    end
  end

  assign done_rise = program_done & ~pd_q;

  state_t          state;
  state_t          state_nx;
  logic [2:0]      sel_nx;
  logic [BZ_W-1:0] buzz_cnt;
  logic [BZ_W-1:0] buzz_nx;

  // Next-state, program-select and buzzer-duration logic; power-off overrides all.
  always_comb begin
    state_nx = state;
    sel_nx   = program_selection;
    buzz_nx  = buzz_cnt;
    if (!power) begin
      state_nx = IDLE;
      sel_nx   = '0;
      buzz_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          // A start event always swallows a simultaneous next event,
          // even when the open door keeps us in IDLE.
          if (press[1]) begin
            if (doorclosed) begin
              state_nx = START;
            end
          end else if (press[0]) begin
            sel_nx = {1'b0, program_selection[1:0] + 2'd1};
          end
        end
        START: begin
          state_nx = RUN;
        end
        RUN: begin
          if (done_rise) begin
            state_nx = DONE;
            buzz_nx  = '0;
          end
        end
        DONE: begin
          if (buzz_cnt == BZ_W'(BUZZ_CYCLES - 1)) begin
            state_nx = IDLE;
            buzz_nx  = '0;
          end else begin
            buzz_nx = buzz_cnt + BZ_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          sel_nx   = '0;
          buzz_nx  = '0;
        end
      endcase
    end
  end

  // State register plus FSM outputs decoded from the next state so they are flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      program_selection <= '0;
      buzz_cnt          <= '0;
      start             <= 1'b0;
      led_running       <= 1'b0;
      buzzer            <= 1'b0;
    end else begin
      state             <= state_nx;
      program_selection <= sel_nx;
      buzz_cnt          <= buzz_nx;
      start             <= (state_nx == START);
      led_running       <= (state_nx == RUN);
      buzzer            <= (state_nx == DONE);
    end
  end

  // Registered BCD conversion of the remaining time, saturating at 99.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_tens <= '0;
      digit_ones <= '0;
    end else if (timer_display > 8'd99) begin
      digit_tens <= 4'd9;
      digit_ones <= 4'd9;
    end else begin
      digit_tens <= 4'(timer_display / 8'd10);
      digit_ones <= 4'(timer_display % 8'd10);
    end
  end

  // Door-open indicator, independent of the sequencing state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_door <= 1'b0;
    end else begin
      led_door <= ~doorclosed;
    end
  end

  logic [BL_W-1:0] blink_cnt;

  // Soap LED blink: count 0 means idle, so the first warning cycle lights the LED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      led_soap  <= 1'b0;
    end else if (!soap_warning) begin
      blink_cnt <= '0;
      led_soap  <= 1'b0;
    end else if (blink_cnt == '0) begin
      blink_cnt <= BL_W'(1);
      led_soap  <= 1'b1;
    end else if (blink_cnt == BL_W'(BLINK_CYCLES)) begin
      blink_cnt <= BL_W'(1);
      led_soap  <= ~led_soap;
    end else begin
      blink_cnt <= blink_cnt + BL_W'(1);
    end
  end

endmodule
